// File: rtl/mem_burst_ctrl.sv
// Burst engine for a single-port synchronous memory: streams write data in
// with zero latency and streams read data out through a 2-entry skid FIFO.
module mem_burst_ctrl #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_base,
   input  logic [AW-1:0] cmd_len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_adr,
   output logic          mem_we,
   output logic [DW-1:0] mem_dat_w,
   input  logic [DW-1:0] mem_dat_r
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   localparam logic [AW-1:0] ADR_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_r;
   state_t        state_s;
   logic [AW-1:0] cur_adr_r;
   logic [AW-1:0] rem_r;
   logic          rd_more_r;
   logic          inflight_r;
   logic          inflight_last_r;
   logic [1:0]    fifo_cnt_r;
   logic [DW-1:0] head_data_r;
   logic          head_last_r;
   logic [DW-1:0] tail_data_r;
   logic          tail_last_r;
   logic          done_r;

   logic          cmd_acc_s;
   logic          wr_hs_s;
   logic          wr_end_s;
   logic          issue_s;
   logic          pop_s;
   logic          last_pop_s;
   logic [2:0]    occ_s;
   logic [2:0]    lim_s;

   // Handshake and read-issue qualification
   always_comb begin
      cmd_acc_s  = 1'b0;
      wr_hs_s    = 1'b0;
      wr_end_s   = 1'b0;
      issue_s    = 1'b0;
      last_pop_s = 1'b0;
      pop_s      = (fifo_cnt_r != 2'd0) & out_ready;
      // A read may only issue if its data is guaranteed a FIFO slot on arrival
      occ_s      = {1'b0, fifo_cnt_r} + {2'b00, inflight_r};
      lim_s      = 3'd2 + {2'b00, pop_s};
      case (state_r)
         ST_IDLE: cmd_acc_s = cmd_valid;
         ST_WR: begin
            wr_hs_s  = in_valid;
            wr_end_s = in_valid & (rem_r == ADR_ZERO);
         end
         ST_RD: begin
            issue_s    = rd_more_r & (occ_s < lim_s);
            last_pop_s = pop_s & head_last_r;
         end
         default: cmd_acc_s = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_acc_s) begin
               state_s = cmd_write ? ST_WR : ST_RD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WR: begin
            if (wr_end_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WR;
            end
         end
         ST_RD: begin
            if (last_pop_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RD;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Address, remaining-count, in-flight tracking and done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_adr_r       <= ADR_ZERO;
         rem_r           <= ADR_ZERO;
         rd_more_r       <= 1'b0;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         done_r          <= 1'b0;
      end else begin
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s & (rem_r == ADR_ZERO);
         done_r          <= wr_end_s | last_pop_s;
         if (cmd_acc_s) begin
            cur_adr_r <= cmd_base;
            rem_r     <= cmd_len;
            rd_more_r <= ~cmd_write;
         end else if (wr_hs_s || issue_s) begin
            cur_adr_r <= cur_adr_r + ADR_ONE;
            if (rem_r == ADR_ZERO) begin
               rd_more_r <= 1'b0;
            end else begin
               rem_r <= rem_r - ADR_ONE;
            end
         end
      end
   end

   // Two-entry read FIFO; head is presented directly on out_data/out_last
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_cnt_r  <= 2'd0;
         head_data_r <= {DW{1'b0}};
         head_last_r <= 1'b0;
         tail_data_r <= {DW{1'b0}};
         tail_last_r <= 1'b0;
      end else begin
         case ({inflight_r, pop_s})
            2'b10: begin
               fifo_cnt_r <= fifo_cnt_r + 2'd1;
               if (fifo_cnt_r == 2'd0) begin
                  head_data_r <= mem_dat_r;
                  head_last_r <= inflight_last_r;
               end else begin
                  tail_data_r <= mem_dat_r;
                  tail_last_r <= inflight_last_r;
               end
            end
            2'b01: begin
               fifo_cnt_r  <= fifo_cnt_r - 2'd1;
               head_data_r <= tail_data_r;
               head_last_r <= tail_last_r;
            end
            2'b11: begin
               if (fifo_cnt_r == 2'd1) begin
                  head_data_r <= mem_dat_r;
                  head_last_r <= inflight_last_r;
               end else begin
                  head_data_r <= tail_data_r;
                  head_last_r <= tail_last_r;
                  tail_data_r <= mem_dat_r;
                  tail_last_r <= inflight_last_r;
               end
            end
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   // Output decode from state and registered FIFO head
   always_comb begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = ADR_ZERO;
      mem_dat_w = {DW{1'b0}};
      case (state_r)
         ST_IDLE: cmd_ready = 1'b1;
         ST_WR: begin
            in_ready  = 1'b1;
            busy      = 1'b1;
            mem_we    = wr_hs_s;
            mem_adr   = cur_adr_r;
            mem_dat_w = in_data;
         end
         ST_RD: begin
            busy    = 1'b1;
            mem_adr = cur_adr_r;
         end
         default: cmd_ready = 1'b0;
      endcase
      out_valid = (fifo_cnt_r != 2'd0);
      out_data  = head_data_r;
      out_last  = head_last_r;
      done      = done_r;
   end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Randomized self-checking bench for mem_burst_ctrl; a shadow memory array is
// the reference for what every write burst stores and every read burst returns.
module tb_mem_burst_ctrl;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_base, cmd_len;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready, out_last;
   logic [DW-1:0] out_data;
   logic          busy, done;
   logic [AW-1:0] mem_adr;
   logic          mem_we;
   logic [DW-1:0] mem_dat_w, mem_dat_r;

   logic [DW-1:0] mem_q  [N];
   logic [DW-1:0] shadow [N];
   logic [DW-1:0] wdata  [N];
   int n_run = 0;
   int n_fail = 0;

   mem_burst_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_base(cmd_base), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done),
      .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
   );

   always #5 clk = ~clk;

   // Synchronous memory: address registered on the edge, data one cycle later
   always @(posedge clk) begin
      if (mem_we) mem_q[mem_adr] <= mem_dat_w;
      mem_dat_r <= mem_q[mem_adr];
   end

   task automatic fill_random;
      for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
   endtask

   task automatic do_write(input logic [3:0] base, input logic [3:0] len, input int gap, output int cyc);
      int idx;
      int k;
      logic [3:0] a;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = base; cmd_len = len;
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_run++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready); end
      @(negedge clk);
      idx = 0; k = 0;
      while (idx <= int'(len) && k < 200) begin
         cmd_valid = 1'($urandom_range(1)); cmd_write = 1'($urandom);
         cmd_base = 4'($urandom); cmd_len = 4'($urandom);
         out_ready = 1'($urandom);
         in_valid = ($urandom_range(99) >= gap);
         in_data = wdata[idx];
         #1;
         a = base + 4'(idx);
         n_run++;
         if ({cmd_ready, in_ready, busy, done} !== 4'b0110) begin
            n_fail++; $display("FAIL wr_status got %b want 0110", {cmd_ready, in_ready, busy, done});
         end
         n_run++;
         if (mem_we !== in_valid) begin n_fail++; $display("FAIL wr_we got %b want %b", mem_we, in_valid); end
         if (in_valid) begin
            n_run++;
            if (mem_adr !== a || mem_dat_w !== wdata[idx]) begin
               n_fail++; $display("FAIL wr_addr_data got %0d/%h want %0d/%h", mem_adr, mem_dat_w, a, wdata[idx]);
            end
            shadow[a] = wdata[idx];
            idx++;
         end
         @(negedge clk);
         k++;
      end
      cyc = k;
      cmd_valid = 1'b0; in_valid = 1'b0; in_data = 8'($urandom);
      #1;
      n_run++;
      if (idx <= int'(len)) begin n_fail++; $display("FAIL wr_timeout got %0d words want %0d", idx, int'(len) + 1); end
      n_run++;
      if ({done, busy, cmd_ready, in_ready, mem_we} !== 5'b10100) begin
         n_fail++; $display("FAIL wr_done got %b want 10100", {done, busy, cmd_ready, in_ready, mem_we});
      end
      n_run++;
      if (mem_adr !== 4'd0 || mem_dat_w !== 8'd0) begin
         n_fail++; $display("FAIL idle_mem got %0d/%h want 0/00", mem_adr, mem_dat_w);
      end
   endtask

   task automatic do_read(input logic [3:0] base, input logic [3:0] len, input int mode, output int cyc);
      int idx;
      int k;
      logic [3:0] a;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = base; cmd_len = len;
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_run++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_ready got %b want 1", cmd_ready); end
      @(negedge clk);
      idx = 0; k = 1;
      while (idx <= int'(len) && k < 400) begin
         cmd_valid = 1'($urandom_range(1)); cmd_write = 1'($urandom);
         cmd_base = 4'($urandom); cmd_len = 4'($urandom);
         in_valid = 1'($urandom); in_data = 8'($urandom);
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1) out_ready = ((k - 1) % 3 == 0);
         else out_ready = 1'($urandom_range(1));
         #1;
         n_run++;
         if ({cmd_ready, in_ready, mem_we, busy, done} !== 5'b00010) begin
            n_fail++; $display("FAIL rd_status got %b want 00010", {cmd_ready, in_ready, mem_we, busy, done});
         end
         if (k < 3) begin
            n_run++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency cycle %0d got valid %b want 0", k, out_valid); end
         end else if (mode == 0) begin
            n_run++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rd_stream cycle %0d got valid %b want 1", k, out_valid); end
         end
         if (out_valid && out_ready) begin
            a = base + 4'(idx);
            n_run++;
            if (out_data !== shadow[a] || out_last !== (idx == int'(len))) begin
               n_fail++; $display("FAIL rd_data word %0d got %h/%b want %h/%b", idx, out_data, out_last, shadow[a], idx == int'(len));
            end
            idx++;
         end
         @(negedge clk);
         k++;
      end
      cyc = k;
      cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'($urandom);
      #1;
      n_run++;
      if (idx <= int'(len)) begin n_fail++; $display("FAIL rd_timeout got %0d words want %0d", idx, int'(len) + 1); end
      n_run++;
      if ({done, busy, cmd_ready, out_valid} !== 4'b1010) begin
         n_fail++; $display("FAIL rd_done got %b want 1010", {done, busy, cmd_ready, out_valid});
      end
   endtask

   task automatic check_idle_done_low;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      n_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_pulse got done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 4'd3; cmd_len = 4'd2;
      in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_run++;
         if ({cmd_ready, in_ready, out_valid, out_last, busy, done, mem_we} !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 1000000", {cmd_ready, in_ready, out_valid, out_last, busy, done, mem_we});
         end
         n_run++;
         if ({out_data, mem_adr, mem_dat_w} !== 20'd0) begin
            n_fail++; $display("FAIL reset_data got %h want 0", {out_data, mem_adr, mem_dat_w});
         end
         @(negedge clk);
         #1;
      end
      cmd_valid = 1'b0; in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_memory;
      int cyc;
      fill_random();
      do_write(4'd5, 4'd15, 30, cyc);
      check_idle_done_low();
      do_read(4'd5, 4'd15, 2, cyc);
      @(negedge clk);
   endtask

   task automatic test_write_basic;
      int cyc;
      wdata[0] = 8'hA1; wdata[1] = 8'hA2; wdata[2] = 8'hA3;
      do_write(4'd3, 4'd2, 0, cyc);
      n_run++;
      if (cyc !== 3) begin n_fail++; $display("FAIL wr_basic_cycles got %0d want 3", cyc); end
      check_idle_done_low();
   endtask

   task automatic test_read_basic;
      int cyc;
      do_read(4'd3, 4'd2, 0, cyc);
      n_run++;
      if (cyc !== 6) begin n_fail++; $display("FAIL rd_basic_cycles got %0d want 6", cyc); end
      check_idle_done_low();
   endtask

   task automatic test_read_toggle;
      int cyc;
      do_read(4'd0, 4'd15, 1, cyc);
      @(negedge clk);
   endtask

   task automatic test_wrap;
      int cyc;
      fill_random();
      do_write(4'd14, 4'd3, 0, cyc);
      @(negedge clk);
      do_read(4'd14, 4'd3, 2, cyc);
      @(negedge clk);
   endtask

   task automatic test_reset_midread;
      int cyc;
      int idx;
      int k;
      logic [3:0] a;
      fill_random();
      do_write(4'd8, 4'd4, 0, cyc);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 4'd8; cmd_len = 4'd4; out_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      idx = 0; k = 0;
      while (idx < 2 && k < 20) begin
         #1;
         if (out_valid) begin
            a = 4'd8 + 4'(idx);
            n_run++;
            if (out_data !== shadow[a]) begin n_fail++; $display("FAIL rst_pre_data got %h want %h", out_data, shadow[a]); end
            idx++;
         end
         @(negedge clk);
         k++;
      end
      rst = 1'b0;
      #1;
      n_run++;
      if ({cmd_ready, in_ready, out_valid, out_last, busy, done, mem_we} !== 7'b1000000) begin
         n_fail++; $display("FAIL rst_mid_ctrl got %b want 1000000", {cmd_ready, in_ready, out_valid, out_last, busy, done, mem_we});
      end
      n_run++;
      if ({out_data, mem_adr, mem_dat_w} !== 20'd0) begin
         n_fail++; $display("FAIL rst_mid_data got %h want 0", {out_data, mem_adr, mem_dat_w});
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         n_run++;
         if ({done, busy, mem_we, out_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_after got %b want 0000", {done, busy, mem_we, out_valid});
         end
      end
      @(negedge clk);
      do_read(4'd8, 4'd4, 0, cyc);
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int cyc;
      fill_random();
      do_write(4'd2, 4'd3, 0, cyc);
      n_run++;
      if ({done, cmd_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_wr_done got %b want 11", {done, cmd_ready}); end
      do_read(4'd2, 4'd3, 0, cyc);
      n_run++;
      if (cyc !== 7) begin n_fail++; $display("FAIL b2b_rd_cycles got %0d want 7", cyc); end
      fill_random();
      do_write(4'd9, 4'd1, 0, cyc);
      n_run++;
      if (cyc !== 2) begin n_fail++; $display("FAIL b2b_wr_cycles got %0d want 2", cyc); end
      check_idle_done_low();
   endtask

   task automatic test_random;
      int cyc;
      logic [3:0] base;
      logic [3:0] len;
      for (int it = 0; it < 12; it++) begin
         base = 4'($urandom); len = 4'($urandom);
         fill_random();
         do_write(base, len, $urandom_range(50), cyc);
         if (it % 2 == 0) check_idle_done_low();
         do_read(base, len, (it % 3 == 0) ? 1 : 2, cyc);
         check_idle_done_low();
      end
   endtask

   initial begin
      test_reset();
      test_full_memory();
      test_write_basic();
      test_read_basic();
      test_read_toggle();
      test_wrap();
      test_reset_midread();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 SHALL have parameter AW, default 4, memory address width (word count 2^AW).
REQ-002 SHALL have parameter DW, default 8, data word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1; command handshake, accepted when both are high.
REQ-006 SHALL have ports cmd_write in 1 (1 = write burst, 0 = read burst), cmd_base in AW (start address), cmd_len in AW (word count minus one).
REQ-007 SHALL have ports in_valid in 1, in_ready out 1, in_data in DW; write-data stream.
REQ-008 SHALL have ports out_valid out 1, out_ready in 1, out_data out DW, out_last out 1; read-data stream.
REQ-009 SHALL have ports busy out 1 (not idle) and done out 1 (burst-complete pulse).
REQ-010 SHALL have ports mem_adr out AW, mem_we out 1, mem_dat_w out DW, mem_dat_r in DW; these drive a memory that registers its address on the clock edge and presents mem_dat_r one cycle after the address.

Function
REQ-011 SHALL implement FSM states IDLE, WR and RD.
REQ-012 SHALL assert cmd_ready only in IDLE.
REQ-013 SHALL, on command accept, latch cur_adr=cmd_base and remaining=cmd_len, then enter WR if cmd_write=1, otherwise RD.
REQ-014 SHALL drive busy=1 exactly when state is not IDLE.
REQ-015 SHALL, in WR, drive in_ready=1 and in_ready=0 in every other state.
REQ-016 SHALL, in WR, drive combinationally mem_we = in_valid & in_ready, mem_adr=cur_adr, mem_dat_w=in_data (zero write latency).
REQ-017 SHALL, on each WR handshake, increment cur_adr modulo 2^AW (wrap 2^AW-1 -> 0).
REQ-018 SHALL, on the WR handshake with remaining=0, return to IDLE; otherwise it SHALL decrement remaining.
REQ-019 SHALL, in RD, hold mem_we=0 and place read addresses on mem_adr.
REQ-020 SHALL contain a 2-entry output FIFO; out_valid = FIFO non-empty; out_data/out_last = FIFO head (registered).
REQ-021 SHALL issue a read in a cycle only if addresses remain and (fifo_count + inflight - pop) < 2, where inflight is 1 if a read was issued in the previous cycle, and pop = out_valid & out_ready.
REQ-022 SHALL push mem_dat_r into the FIFO in the cycle after a read issue, tagged last=1 for the final address.
REQ-023 SHALL never drop or duplicate a word under arbitrary out_ready backpressure.
REQ-024 SHALL sustain one word per cycle when out_ready is held high.
REQ-025 SHALL present out_valid first 2 cycles after the first read issue.
REQ-026 SHALL increment read addresses modulo 2^AW.
REQ-027 SHALL leave RD for IDLE when the out_last word is popped.
REQ-028 SHALL pulse done high for exactly one cycle, in the cycle after the final WR handshake or final out_last pop.
REQ-029 SHALL accept a new command in the same cycle as done (state is already IDLE).
REQ-030 SHALL, in IDLE, drive mem_adr=0, mem_we=0, mem_dat_w=0.
REQ-031 SHALL treat cmd_len=2^AW-1 as a full-memory burst of 2^AW words.
REQ-032 SHALL ignore in_valid outside WR and ignore cmd_valid while busy.

Reset
REQ-033 SHALL, while rst=0, immediately force: state IDLE; FIFO and inflight cleared; cmd_ready=1; in_ready=0; out_valid=0; out_last=0; out_data=0; busy=0; done=0; mem_we=0; mem_adr=0; mem_dat_w=0.
REQ-034 SHALL, on reset mid-burst, abort the burst with no done pulse and no further mem_we.

Verification
REQ-035 SHALL be tested: write burst base=3, len=2, data A1,A2,A3, in_valid always high -> mem_we for 3 consecutive cycles at addresses 3,4,5; done one cycle after the third write.
REQ-036 SHALL be tested: read back base=3, len=2, out_ready=1 -> out_data A1,A2,A3 on consecutive cycles, out_last only on A3; first out_valid 3 cycles after cmd accept.
REQ-037 SHALL be tested: read with out_ready toggling 1,0,0,1,... over 16 words -> all 16 words delivered in order, no loss or duplication, FIFO never exceeds 2 entries.
REQ-038 SHALL be tested: wrap-around write base=14, len=3 -> writes to addresses 14,15,0,1.
REQ-039 SHALL be tested: rst driven low after the 2nd word of a 5-word read -> outputs at reset values immediately, no done pulse; a subsequent command executes normally.
REQ-040 SHALL be tested: back-to-back commands with the new cmd_valid asserted in the done cycle -> accepted in that cycle, with no idle gap beyond it.
